// File: rtl/disp_scan.sv
// Six-digit multiplexed LED scanner for an HH.MM.SS clock display.
// It blanks between digits, latches its inputs once per frame, blinks selected digits and drives a lamp test.
module disp_scan #(
    parameter int DWELL      = 2,
    parameter int BLINK_HALF = 250
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] seg_in,
    input  logic [3:0] bcd1,
    input  logic [3:0] bcd2,
    input  logic [3:0] bcd3,
    input  logic [3:0] bcd4,
    input  logic [3:0] bcd5,
    input  logic [5:0] blink_mask,
    input  logic       alarm_flag,
    input  logic       lamp_test,
    output logic [6:0] seg_out,
    output logic [5:0] dig_n,
    output logic       dp_out
);

    localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);
    localparam logic [9:0] BLINK_LAST = 10'(BLINK_HALF - 1);
    localparam logic [2:0] IDX_LAST   = 3'd5;

    logic [7:0] dwell_cnt;
    logic [2:0] idx;
    logic [9:0] blink_cnt;
    logic       phase;

    logic [6:0] sh_seg;
    logic [3:0] sh_bcd1, sh_bcd2, sh_bcd3, sh_bcd4, sh_bcd5;
    logic [5:0] sh_mask;
    logic       sh_alarm;

    logic       dwell_wrap;
    logic       shadow_load;
    logic [6:0] digit_seg;
    logic       sep_digit;
    logic [6:0] nxt_seg;
    logic [5:0] nxt_dig;
    logic       nxt_dp;

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] v);
        case (v)
            4'd0:    bcd_to_seg = 7'b0111111;
            4'd1:    bcd_to_seg = 7'b0000110;
            4'd2:    bcd_to_seg = 7'b1011011;
            4'd3:    bcd_to_seg = 7'b1001111;
            4'd4:    bcd_to_seg = 7'b1100110;
            4'd5:    bcd_to_seg = 7'b1101101;
            4'd6:    bcd_to_seg = 7'b1111101;
            4'd7:    bcd_to_seg = 7'b0000111;
            4'd8:    bcd_to_seg = 7'b1111111;
            4'd9:    bcd_to_seg = 7'b1101111;
            default: bcd_to_seg = 7'b0000000;
        endcase
    endfunction

    assign dwell_wrap  = (dwell_cnt == DWELL_LAST);
    assign shadow_load = (idx == 3'd0) && (dwell_cnt == 8'd0);

    // NOTE: every output of this block is given a default first so no latch is inferred.
    always_comb begin
        digit_seg = 7'b0000000;
        nxt_seg   = 7'b0000000;
        nxt_dig   = 6'b111111;
        nxt_dp    = 1'b0;

        case (idx)
            3'd0:    digit_seg = sh_seg;
            3'd1:    digit_seg = bcd_to_seg(sh_bcd1);
            3'd2:    digit_seg = bcd_to_seg(sh_bcd2);
            3'd3:    digit_seg = bcd_to_seg(sh_bcd3);
            3'd4:    digit_seg = bcd_to_seg(sh_bcd4);
            3'd5:    digit_seg = bcd_to_seg(sh_bcd5);
            default: digit_seg = 7'b0000000;
        endcase
        sep_digit = (idx == 3'd2) || (idx == 3'd4);

        // The dwell=0 cycle of each slot stays dark so the previous digit does not ghost.
        if (dwell_cnt != 8'd0) begin
            nxt_dig = ~(6'b000001 << idx);
            if (lamp_test) begin
                nxt_seg = 7'h7F;
                nxt_dp  = 1'b1;
            end else begin
                nxt_seg = (!phase && sh_mask[idx]) ? 7'b0000000 : digit_seg;
                nxt_dp  = sep_digit && (!sh_alarm || phase);
            end
        end
    end

    // NOTE: state updates use non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            dwell_cnt <= 8'd0;
            idx       <= 3'd0;
            blink_cnt <= 10'd0;
            phase     <= 1'b1;
            sh_seg    <= 7'b0111111;
            sh_bcd1   <= 4'd0;
            sh_bcd2   <= 4'd0;
            sh_bcd3   <= 4'd0;
            sh_bcd4   <= 4'd0;
            sh_bcd5   <= 4'd0;
            sh_mask   <= 6'd0;
            sh_alarm  <= 1'b0;
            seg_out   <= 7'b0000000;
            dig_n     <= 6'b111111;
            dp_out    <= 1'b0;
        end else begin
            if (dwell_wrap) begin
                dwell_cnt <= 8'd0;
                idx       <= (idx == IDX_LAST) ? 3'd0 : idx + 3'd1;
            end else begin
                dwell_cnt <= dwell_cnt + 8'd1;
            end

            if (blink_cnt == BLINK_LAST) begin
                blink_cnt <= 10'd0;
                phase     <= ~phase;
            end else begin
                blink_cnt <= blink_cnt + 10'd1;
            end

            // Latch once per frame so a display update never tears across digits.
            if (shadow_load) begin
                sh_seg   <= seg_in;
                sh_bcd1  <= bcd1;
                sh_bcd2  <= bcd2;
                sh_bcd3  <= bcd3;
                sh_bcd4  <= bcd4;
                sh_bcd5  <= bcd5;
                sh_mask  <= blink_mask;
                sh_alarm <= alarm_flag;
            end

            seg_out <= nxt_seg;
            dig_n   <= nxt_dig;
            dp_out  <= nxt_dp;
        end
    end

endmodule

// File: tb/tb_disp_scan.sv
// Directed bench for disp_scan with DWELL=2, BLINK_HALF=4.
// Cycle k counts rising edges after reset release; the outputs after edge k reflect the state before it.
module tb_disp_scan;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] seg_in;
    logic [3:0] bcd1, bcd2, bcd3, bcd4, bcd5;
    logic [5:0] blink_mask;
    logic       alarm_flag;
    logic       lamp_test;
    logic [6:0] seg_out;
    logic [5:0] dig_n;
    logic       dp_out;

    int n_tests = 0;
    int n_fail  = 0;
    int k       = -1;

    disp_scan #(.DWELL(2), .BLINK_HALF(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .seg_in     (seg_in),
        .bcd1       (bcd1),
        .bcd2       (bcd2),
        .bcd3       (bcd3),
        .bcd4       (bcd4),
        .bcd5       (bcd5),
        .blink_mask (blink_mask),
        .alarm_flag (alarm_flag),
        .lamp_test  (lamp_test),
        .seg_out    (seg_out),
        .dig_n      (dig_n),
        .dp_out     (dp_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s k=%0d: got %b, expected %b", tag, k, got[13:0], exp[13:0]);
        end
    endtask

    // Packs {dig_n, seg_out, dp_out} so one comparison covers a whole output vector.
    task automatic check_out(input string tag, input logic [5:0] e_dig, input logic [6:0] e_seg,
                             input logic e_dp);
        check(tag, {18'd0, dig_n, seg_out, dp_out}, {18'd0, e_dig, e_seg, e_dp});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        k++;
    endtask

    task automatic run_to(input int target);
        while (k < target) tick();
    endtask

    localparam logic [5:0] BLANK_D = 6'b111111;

    logic [5:0] f_dig [12];
    logic [6:0] f_seg [12];
    logic       f_dp  [12];

    initial begin
        f_dig = '{BLANK_D, 6'b111110, BLANK_D, 6'b111101, BLANK_D, 6'b111011,
                  BLANK_D, 6'b110111, BLANK_D, 6'b101111, BLANK_D, 6'b011111};
        f_seg = '{7'b0, 7'b1101111, 7'b0, 7'b0000110, 7'b0, 7'b1011011,
                  7'b0, 7'b1001111, 7'b0, 7'b1100110, 7'b0, 7'b1101101};
        f_dp  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

        rst        = 1'b1;
        seg_in     = 7'b1101111;
        bcd1       = 4'd1;
        bcd2       = 4'd2;
        bcd3       = 4'd3;
        bcd4       = 4'd4;
        bcd5       = 4'd5;
        blink_mask = 6'b000000;
        alarm_flag = 1'b0;
        lamp_test  = 1'b0;

        tick();
        tick();
        check_out("reset_state", BLANK_D, 7'b0, 1'b0);
        rst = 1'b0;
        k   = -1;

        // Two full frames of the plain scan sequence.
        for (int i = 0; i < 24; i++) begin
            tick();
            check_out("scan_order", f_dig[i % 12], f_seg[i % 12], f_dp[i % 12]);
        end

        // Coherency: change digits mid-frame while index=1.
        run_to(26);
        bcd3 = 4'd7;
        bcd2 = 4'hA;
        run_to(29);
        check_out("coh_d2_old", 6'b111011, 7'b1011011, 1'b1);
        run_to(31);
        check_out("coh_d3_old", 6'b110111, 7'b1001111, 1'b0);
        run_to(41);
        check_out("coh_d2_blank_bcd", 6'b111011, 7'b0000000, 1'b1);
        run_to(43);
        check_out("coh_d3_new", 6'b110111, 7'b0000111, 1'b0);

        // Blink/dp with alarm active; phase is 1 when (k/4) is even.
        run_to(44);
        blink_mask = 6'b000001;
        alarm_flag = 1'b1;
        run_to(49);
        check_out("blink_d0_vis", 6'b111110, 7'b1101111, 1'b0);
        run_to(51);
        check_out("blink_d1_unmasked", 6'b111101, 7'b0000110, 1'b0);
        run_to(53);
        check_out("alarm_d2_dp_off", 6'b111011, 7'b0000000, 1'b0);
        run_to(57);
        check_out("alarm_d4_dp_on", 6'b101111, 7'b1100110, 1'b1);
        run_to(61);
        check_out("blink_d0_dark", 6'b111110, 7'b0000000, 1'b0);
        run_to(65);
        check_out("alarm_d2_dp_on", 6'b111011, 7'b0000000, 1'b1);
        run_to(69);
        check_out("alarm_d4_dp_off", 6'b101111, 7'b1100110, 1'b0);

        // Lamp test during a phase=0 window with every digit masked.
        blink_mask = 6'b111111;
        run_to(75);
        check_out("lamp_before", 6'b111101, 7'b0000110, 1'b0);
        lamp_test = 1'b1;
        run_to(76);
        check_out("lamp_blank_kept", BLANK_D, 7'b0, 1'b0);
        run_to(77);
        check_out("lamp_on", 6'b111011, 7'h7F, 1'b1);
        lamp_test = 1'b0;
        run_to(78);
        check_out("lamp_off_blank", BLANK_D, 7'b0, 1'b0);
        run_to(79);
        check_out("lamp_off_normal", 6'b110111, 7'b0000000, 1'b0);

        // Reset mid-scan, held three edges, then restart from a shadow-load cycle.
        run_to(80);
        rst    = 1'b1;
        seg_in = 7'b0000001;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_out("mid_reset", BLANK_D, 7'b0, 1'b0);
        end
        rst = 1'b0;
        k   = -1;
        tick();
        check_out("post_reset_blank", BLANK_D, 7'b0, 1'b0);
        tick();
        check_out("post_reset_d0", 6'b111110, 7'b0000001, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
